// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : skew_feeder
// Purpose  : Operand feeder for a systolic array. Buffers one frame of
//            LANES*VECTOR words arriving serially in lane-major order, then
//            streams all lanes in parallel with a diagonal skew: lane i is
//            delayed by i cycles relative to lane 0.
// Ports    : clk          - clock, all state on rising edge
//            rst          - asynchronous active-low reset
//            load_valid   - load_data carries a word
//            load_ready   - feeder accepts a word this cycle (registered)
//            load_data    - frame word, WIDTH bits
//            start        - stream the buffered frame (honoured in FULL)
//            clear        - discard the buffered frame (honoured in FULL)
//            busy         - streaming in progress
//            done         - one-cycle pulse after the last streamed word
//            lane_out     - lane i at bits [(i+1)*WIDTH-1 : i*WIDTH]
//            lane_valid   - bit i qualifies lane i of lane_out
// Config   : SKEW_FEEDER_REPLAY_EN - when defined, the frame is retained after
//            streaming (DONE returns to FULL) so it can be re-streamed; a
//            clear is then needed before a new frame can be loaded.
// Revision : 1.0 - initial release
// ============================================================================
module skew_feeder #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int VECTOR = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     start,
  input  logic                     clear,
  output logic                     busy,
  output logic                     done,
  output logic [LANES*WIDTH-1:0]   lane_out,
  output logic [LANES-1:0]         lane_valid
);

  localparam int DEPTH = LANES * VECTOR;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STEPS = VECTOR + LANES - 1;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] FULL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [AW-1:0]          ldcnt;
  logic [SW-1:0]          scnt;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   accept;

  logic                   load_ready_next;
  logic                   busy_next;
  logic                   done_next;
  logic [LANES*WIDTH-1:0] lane_out_next;
  logic [LANES-1:0]       lane_valid_next;

  // load_ready is low for the first cycle after reset even though the state
  // is already LOAD, so the handshake must use the registered ready.
  assign accept = load_valid && load_ready && (state == LOAD);

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      ldcnt <= '0;
      scnt  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        ldcnt <= (ldcnt == LAST_WORD) ? '0 : ldcnt + 1'b1;
      end
      // scnt sits at 0 outside STREAM so every stream begins at step 0
      if ((state == STREAM) && (scnt != LAST_STEP)) begin
        scnt <= scnt + 1'b1;
      end else begin
        scnt <= '0;
      end
    end
  end

  // Frame buffer: no reset, contents only change on an accepted load word
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ldcnt] <= load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (accept && (ldcnt == LAST_WORD)) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (clear) begin
          state_next = LOAD;
        end else if (start) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (scnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
`ifdef SKEW_FEEDER_REPLAY_EN
        state_next = FULL;
`else
        state_next = LOAD;
`endif
      end
      default: state_next = LOAD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    load_ready_next = (state_next == LOAD);
    busy_next       = (state == STREAM);
    done_next       = (state == DONE);
  end

  // At stream step t, lane i shows element t-i. Its buffer address
  // i*VECTOR + (t-i) simplifies to i*(VECTOR-1) + t, which stays inside the
  // buffer for every t, so no range guard is needed on the read itself.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    int            diff;
    logic          hit;
    logic [AW-1:0] rd_addr;

    assign diff    = int'(scnt) - i;
    assign hit     = (state == STREAM) && (diff >= 0) && (diff < VECTOR);
    assign rd_addr = AW'(i * (VECTOR - 1)) + AW'(scnt);

    assign lane_valid_next[i]                 = hit;
    assign lane_out_next[i*WIDTH +: WIDTH]    = hit ? mem[rd_addr] : '0;
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lane_out   <= '0;
      lane_valid <= '0;
    end else begin
      load_ready <= load_ready_next;
      busy       <= busy_next;
      done       <= done_next;
      lane_out   <= lane_out_next;
      lane_valid <= lane_valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_feeder
// Purpose  : Self-checking bench for skew_feeder (LANES=4, VECTOR=4,
//            WIDTH=16). A table of stream-cycle records holds the expected
//            diagonal pattern for a frame of words 0x0001..0x0010; hand-written
//            sequences cover handshake gaps, ignored start/clear, resets in
//            the middle of a load or a stream, and frame replay when
//            SKEW_FEEDER_REPLAY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skew_feeder;

  localparam int WIDTH  = 16;
  localparam int LANES  = 4;
  localparam int VECTOR = 4;
  localparam int ROWS   = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   load_valid = 1'b0;
  logic [WIDTH-1:0]       load_data = '0;
  logic                   start = 1'b0;
  logic                   clear = 1'b0;
  logic                   load_ready;
  logic                   busy;
  logic                   done;
  logic [LANES*WIDTH-1:0] lane_out;
  logic [LANES-1:0]       lane_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skew_feeder #(
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .VECTOR (VECTOR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .start      (start),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .lane_out   (lane_out),
    .lane_valid (lane_valid)
  );

  typedef struct {
    logic        start;
    logic        clear;
    logic [63:0] lanes;
    logic [3:0]  valid;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [ROWS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Load n words base+1..base+n; optionally toggle load_valid and hold start.
  task automatic load_words(input int n, input logic [15:0] base, input bit toggle,
                            input bit with_start, output int ready_cycles);
    int  accepted;
    int  cyc;
    bit  hs;
    accepted     = 0;
    cyc          = 0;
    ready_cycles = 0;
    while (accepted < n && cyc < 200) begin
      load_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      load_data  = load_valid ? (base + 16'(accepted) + 16'd1) : 16'hDEAD;
      start      = with_start;
      if (load_ready) ready_cycles++;
      hs = load_valid && load_ready;
      step();
      if (hs) accepted++;
      cyc++;
    end
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    check("load_accepted_count", 64'(accepted), 64'(n));
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      start = tbl[r].start;
      clear = tbl[r].clear;
      step();
      check($sformatf("%s_row%0d_lane_out", tag, r), lane_out, tbl[r].lanes);
      check($sformatf("%s_row%0d_lane_valid", tag, r), 64'(lane_valid), 64'(tbl[r].valid));
      check($sformatf("%s_row%0d_busy", tag, r), 64'(busy), 64'(tbl[r].busy));
      check($sformatf("%s_row%0d_done", tag, r), 64'(done), 64'(tbl[r].done));
    end
    start = 1'b0;
    clear = 1'b0;
  endtask

  // In replay builds a streamed frame is retained; release it before reloading.
  task automatic release_frame();
`ifdef SKEW_FEEDER_REPLAY_EN
    clear = 1'b1;
    step();
    clear = 1'b0;
`endif
  endtask

  initial begin
    int rc;

    // Row 0 samples start; rows 1..7 are stream cycles 0..6; row 8 is done.
    tbl[0] = '{1'b1, 1'b0, 64'h0000_0000_0000_0000, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 64'h0000_0000_0000_0001, 4'b0001, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 64'h0000_0000_0005_0002, 4'b0011, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 64'h0000_0009_0006_0003, 4'b0111, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 64'h000D_000A_0007_0004, 4'b1111, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 64'h000E_000B_0008_0000, 4'b1110, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 64'h000F_000C_0000_0000, 4'b1100, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 64'h0010_0000_0000_0000, 4'b1000, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 64'h0000_0000_0000_0000, 4'b0000, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 64'h0000_0000_0000_0000, 4'b0000, 1'b0, 1'b0};

    // ---- reset state ----
    step();
    step();
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lane_valid", 64'(lane_valid), 64'd0);
    check("rst_lane_out", lane_out, 64'd0);
    rst = 1'b1;
    #1;
    check("release_ready_still_low", 64'(load_ready), 64'd0);
    step();
    check("release_ready_rises", 64'(load_ready), 64'd1);

    // ---- basic frame, load_valid held ----
    load_words(16, 16'h0000, 1'b0, 1'b0, rc);
    check("held_ready_cycles", 64'(rc), 64'd16);
    check("full_ready_low", 64'(load_ready), 64'd0);
    step();
    check("full_idle_busy", 64'(busy), 64'd0);
    run_table("basic");
`ifdef SKEW_FEEDER_REPLAY_EN
    check("replay_ready_after_done", 64'(load_ready), 64'd0);
    run_table("replay");
    check("replay_ready_after_second", 64'(load_ready), 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("replay_clear_ready", 64'(load_ready), 64'd1);
`else
    check("ready_after_done", 64'(load_ready), 64'd1);
`endif

    // ---- toggled load_valid ----
    load_words(16, 16'h0000, 1'b1, 1'b0, rc);
    check("toggle_full_ready_low", 64'(load_ready), 64'd0);
    step();
    run_table("toggle");
    release_frame();

    // ---- start during LOAD ignored, start+clear in FULL: clear wins ----
    load_words(8, 16'h0000, 1'b0, 1'b1, rc);
    check("midload_start_busy", 64'(busy), 64'd0);
    check("midload_start_ready", 64'(load_ready), 64'd1);
    load_words(8, 16'h0008, 1'b0, 1'b0, rc);
    check("sc_full_ready_low", 64'(load_ready), 64'd0);
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    check("sc_ready_back", 64'(load_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("sc_no_stream_valid%0d", c), 64'(lane_valid), 64'd0);
      check($sformatf("sc_no_stream_busy%0d", c), 64'(busy), 64'd0);
    end

    // ---- reset mid-load: partial frame lost, ldcnt restarts at 0 ----
    load_words(5, 16'hA000, 1'b0, 1'b0, rc);
    rst = 1'b0;
    #1;
    check("midload_rst_ready", 64'(load_ready), 64'd0);
    step();
    rst = 1'b1;
    step();
    check("midload_rst_ready_back", 64'(load_ready), 64'd1);
    load_words(16, 16'h0000, 1'b0, 1'b0, rc);
    step();
    run_table("after_load_rst");
    release_frame();

    // ---- reset during stream cycle 3 ----
    load_words(16, 16'h0000, 1'b0, 1'b0, rc);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("stream3_valid_before_rst", 64'(lane_valid), 64'hF);
    rst = 1'b0;
    #1;
    check("stream_rst_lane_out", lane_out, 64'd0);
    check("stream_rst_lane_valid", 64'(lane_valid), 64'd0);
    check("stream_rst_busy", 64'(busy), 64'd0);
    check("stream_rst_done", 64'(done), 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("stream_rst_ready_low", 64'(load_ready), 64'd0);
    step();
    check("stream_rst_ready_back", 64'(load_ready), 64'd1);
    load_words(16, 16'h0000, 1'b0, 1'b0, rc);
    step();
    run_table("after_stream_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
